// File: rtl/pipa_pulse_source.sv
// PIPA pulse transmitter: drains a signed per-axis backlog as plus/minus pulses,
// at most one pulse per axis per PIPSAM_ sample window, with an optional idle gap.
module pipa_pulse_source #(
  parameter int CW  = 8,
  parameter int GAP = 0
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 PIPSAM_,
  input  logic                 LOAD,
  input  logic [1:0]           AXIS,
  input  logic signed [CW-1:0] DV,
  output logic                 PIPAXp,
  output logic                 PIPAXm,
  output logic                 PIPAYp,
  output logic                 PIPAYm,
  output logic                 PIPAZp,
  output logic                 PIPAZm,
  output logic                 PIPAXp_,
  output logic                 PIPAXm_,
  output logic                 PIPAYp_,
  output logic                 PIPAYm_,
  output logic                 PIPAZp_,
  output logic                 PIPAZm_,
  output logic                 IDLE,
  output logic                 OVF
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic signed [CW+1:0] MAXV = {3'b000, {(CW-1){1'b1}}};
  localparam logic signed [CW+1:0] MINV = {3'b111, {(CW-1){1'b0}}};

  logic                 psam_q;
  logic                 win_end;
  logic signed [CW-1:0] bl_q   [3];
  logic signed [CW-1:0] bl_d   [3];
  logic [GW-1:0]        gap_q  [3];
  logic [GW-1:0]        gap_d  [3];
  logic signed [CW+1:0] step   [3];
  logic signed [CW+1:0] sum    [3];
  logic [2:0]           p_q, p_d, m_q, m_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    win_end = ~psam_q & PIPSAM_;
    ovf_d   = ovf_q;
    p_d     = p_q;
    m_d     = m_q;
    for (int a = 0; a < 3; a++) begin
      gap_d[a] = gap_q[a];
      step[a]  = '0;
      if (win_end) begin
        p_d[a] = 1'b0;
        m_d[a] = 1'b0;
        // A window carrying a pulse always ends in a deasserted window, so
        // polarity can never flip back-to-back.
        if (!(p_q[a] || m_q[a])) begin
          if (gap_q[a] != '0) begin
            gap_d[a] = gap_q[a] - 1'b1;
          end else if (bl_q[a] > 0) begin
            p_d[a]   = 1'b1;
            step[a]  = 1;
            gap_d[a] = GW'(GAP);
          end else if (bl_q[a] < 0) begin
            m_d[a]   = 1'b1;
            step[a]  = -1;
            gap_d[a] = GW'(GAP);
          end
        end
      end
      sum[a] = {{2{bl_q[a][CW-1]}}, bl_q[a]} - step[a];
      if (LOAD && (AXIS == a[1:0])) begin
        sum[a] = sum[a] + {{2{DV[CW-1]}}, DV};
      end
      if (sum[a] > MAXV) begin
        bl_d[a] = MAXV[CW-1:0];
        ovf_d   = 1'b1;
      end else if (sum[a] < MINV) begin
        bl_d[a] = MINV[CW-1:0];
        ovf_d   = 1'b1;
      end else begin
        bl_d[a] = sum[a][CW-1:0];
      end
    end
  end

  // Edge history resets high so a low PIPSAM_ at release is not a window end.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      psam_q <= 1'b1;
      p_q    <= '0;
      m_q    <= '0;
      ovf_q  <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        bl_q[a]  <= '0;
        gap_q[a] <= '0;
      end
    end else begin
      psam_q <= PIPSAM_;
      p_q    <= p_d;
      m_q    <= m_d;
      ovf_q  <= ovf_d;
      for (int a = 0; a < 3; a++) begin
        bl_q[a]  <= bl_d[a];
        gap_q[a] <= gap_d[a];
      end
    end
  end

  assign PIPAXp  = p_q[0];
  assign PIPAXm  = m_q[0];
  assign PIPAYp  = p_q[1];
  assign PIPAYm  = m_q[1];
  assign PIPAZp  = p_q[2];
  assign PIPAZm  = m_q[2];
  assign PIPAXp_ = ~p_q[0];
  assign PIPAXm_ = ~m_q[0];
  assign PIPAYp_ = ~p_q[1];
  assign PIPAYm_ = ~m_q[1];
  assign PIPAZp_ = ~p_q[2];
  assign PIPAZm_ = ~m_q[2];

  assign IDLE = (bl_q[0] == '0) && (bl_q[1] == '0) && (bl_q[2] == '0) &&
                (p_q == '0) && (m_q == '0);
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_pipa_pulse_source.sv
// Directed bench for pipa_pulse_source: GAP=0 and GAP=2 instances share the
// PIPSAM_ strobe; per-window expectations come from a vector table.
module tb_pipa_pulse_source;

  logic CLOCK = 1'b0;
  logic rst, psam, ld0, ld2;
  logic [1:0] axis;
  logic signed [7:0] dv;

  logic a_xp, a_xm, a_yp, a_ym, a_zp, a_zm, a_xpn, a_xmn, a_ypn, a_ymn, a_zpn, a_zmn, a_idle, a_ovf;
  logic b_xp, b_xm, b_yp, b_ym, b_zp, b_zm, b_xpn, b_xmn, b_ypn, b_ymn, b_zpn, b_zmn, b_idle, b_ovf;

  always #5 CLOCK = ~CLOCK;

  pipa_pulse_source #(.CW(8), .GAP(0)) dut0 (
    .CLOCK(CLOCK), .rst(rst), .PIPSAM_(psam), .LOAD(ld0), .AXIS(axis), .DV(dv),
    .PIPAXp(a_xp), .PIPAXm(a_xm), .PIPAYp(a_yp), .PIPAYm(a_ym), .PIPAZp(a_zp), .PIPAZm(a_zm),
    .PIPAXp_(a_xpn), .PIPAXm_(a_xmn), .PIPAYp_(a_ypn), .PIPAYm_(a_ymn),
    .PIPAZp_(a_zpn), .PIPAZm_(a_zmn), .IDLE(a_idle), .OVF(a_ovf));

  pipa_pulse_source #(.CW(8), .GAP(2)) dut2 (
    .CLOCK(CLOCK), .rst(rst), .PIPSAM_(psam), .LOAD(ld2), .AXIS(axis), .DV(dv),
    .PIPAXp(b_xp), .PIPAXm(b_xm), .PIPAYp(b_yp), .PIPAYm(b_ym), .PIPAZp(b_zp), .PIPAZm(b_zm),
    .PIPAXp_(b_xpn), .PIPAXm_(b_xmn), .PIPAYp_(b_ypn), .PIPAYm_(b_ymn),
    .PIPAZp_(b_zpn), .PIPAZm_(b_zmn), .IDLE(b_idle), .OVF(b_ovf));

  wire [13:0] obs0 = {a_xp, a_xm, a_yp, a_ym, a_zp, a_zm,
                      a_xpn, a_xmn, a_ypn, a_ymn, a_zpn, a_zmn, a_idle, a_ovf};
  wire [13:0] obs2 = {b_xp, b_xm, b_yp, b_ym, b_zp, b_zm,
                      b_xpn, b_xmn, b_ypn, b_ymn, b_zpn, b_zmn, b_idle, b_ovf};

  // exp bit order: Xp Xm Yp Ym Zp Zm
  typedef struct {
    bit                sel;
    bit                ld;
    bit [1:0]          axis;
    logic signed [7:0] dv;
    bit                win;
    bit [5:0]          exp;
    bit                idle;
    bit                ovf;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(bit sel, bit ld, bit [1:0] ax, int d, bit win,
                              bit [5:0] exp, bit idle, bit ovf);
    vec_t v;
    v.sel = sel; v.ld = ld; v.axis = ax; v.dv = 8'(d); v.win = win;
    v.exp = exp; v.idle = idle; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(string name, logic [13:0] got, logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic do_load(bit sel, logic [1:0] ax, logic signed [7:0] d);
    axis = ax; dv = d;
    if (sel) ld2 = 1'b1; else ld0 = 1'b1;
    @(negedge CLOCK);
    ld0 = 1'b0; ld2 = 1'b0;
  endtask

  task automatic window();
    psam = 1'b0;
    repeat (3) @(negedge CLOCK);
    psam = 1'b1;
    repeat (2) @(negedge CLOCK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n;
    vec_t v;

    // GAP=0 drain of X +3
    vecs.push_back(mk(0, 1, 0,  3, 1, 6'b100000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b100000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b100000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 1, 0));
    // Y -2 and Z +1 in parallel
    vecs.push_back(mk(0, 1, 1, -2, 0, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 1, 2,  1, 1, 6'b000110, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000100, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 1, 0));
    // reversal while a p pulse is up
    vecs.push_back(mk(0, 1, 0,  1, 1, 6'b100000, 0, 0));
    vecs.push_back(mk(0, 1, 0, -2, 0, 6'b100000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b010000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b010000, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 6'b000000, 1, 0));
    // GAP=2 instance: AXIS=3 ignored, Z +2 pulses in windows 2 and 6
    vecs.push_back(mk(1, 1, 3,  5, 0, 6'b000000, 1, 0));
    vecs.push_back(mk(1, 1, 2,  2, 1, 6'b000010, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 6'b000000, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 6'b000010, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 6'b000000, 1, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 6'b000000, 1, 0));
    // saturation
    vecs.push_back(mk(0, 1, 0, 120, 0, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 1, 0,  20, 0, 6'b000000, 0, 1));

    rst = 1'b1; psam = 1'b0; ld0 = 1'b0; ld2 = 1'b0; axis = '0; dv = '0;
    repeat (3) @(negedge CLOCK);
    check("reset0", obs0, {6'b0, 6'h3f, 1'b1, 1'b0});
    check("reset2", obs2, {6'b0, 6'h3f, 1'b1, 1'b0});

    rst = 1'b0;
    do_load(0, 0, 1);
    window();
    check("pre_rst", obs0, {6'b100000, 6'b011111, 1'b0, 1'b0});
    psam = 1'b0;
    @(negedge CLOCK);
    #2 rst = 1'b1;
    #1 check("async_rst", obs0, {6'b0, 6'h3f, 1'b1, 1'b0});
    @(negedge CLOCK);
    rst = 1'b0;
    repeat (2) @(negedge CLOCK);
    psam = 1'b1;
    repeat (2) @(negedge CLOCK);
    check("post_rst", obs0, {6'b0, 6'h3f, 1'b1, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.ld) do_load(v.sel, v.axis, v.dv);
      if (v.win) window();
      check($sformatf("row%0d", i), v.sel ? obs2 : obs0, {v.exp, ~v.exp, v.idle, v.ovf});
    end

    // LOAD +1 in the same cycle as the window-end step at backlog 127
    psam = 1'b0;
    repeat (3) @(negedge CLOCK);
    psam = 1'b1; ld0 = 1'b1; axis = 2'd0; dv = 8'sd1;
    @(negedge CLOCK);
    ld0 = 1'b0;
    @(negedge CLOCK);
    check("coincide", obs0, {6'b100000, 6'b011111, 1'b0, 1'b1});

    cnt = 1; n = 0;
    while (!a_idle && n < 400) begin
      window();
      if (a_xp) cnt++;
      n++;
    end
    check("sat_count", 14'(cnt), 14'd128);

    #2 rst = 1'b1;
    #1 check("ovf_clear", obs0, {6'b0, 6'h3f, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipa_pulse_source.md
Name: pipa_pulse_source

Overview:
- Bench-side transmitter for the PIPA accelerometer pulse interface consumed by the AGC counter logic.
- Holds a signed backlog of velocity-increment counts per axis (X, Y, Z) and drains it as PIPA plus/minus pulses, at most one per axis per AGC sample window delimited by PIPSAM_.
- Lets module testbenches drive realistic, protocol-correct PIPA traffic into the four-bit and counter modules.

Parameters:
- CW, 8, width of each signed pending-count register and of DV (two's complement).
- GAP, 0, number of extra sample windows an axis must stay idle after emitting a pulse (0 = a pulse every window).

Ports:
- CLOCK  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous active-high reset
- PIPSAM_  input  1  AGC sample strobe, active low; low interval = sample window
- LOAD  input  1  one-cycle strobe: add DV to the backlog of axis AXIS
- AXIS  input  2  0=X, 1=Y, 2=Z, 3=ignored (LOAD has no effect)
- DV  input  CW  signed count increment
- PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  output  1 each  active-high pulses
- PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_  output  1 each  exact complements of the above
- IDLE  output  1  high when all three backlogs are 0 and no pulse output is asserted
- OVF  output  1  sticky; set when any LOAD saturates; cleared only by rst

Behaviour:
- Reset (async, any time, including mid-window):
  - backlogs = 0, GAP counters = 0, active-high pulses = 0, _ outputs = 1, IDLE = 1, OVF = 0.
  - PIPSAM_ edge history is reset to 1, so a low PIPSAM_ at reset release does not count as a rising edge until it returns high.
- PIPSAM_ is registered once (prev). A rising edge (prev=0, now=1) is the window end. This event is the only time pulse outputs change.
- At each window end, per axis, evaluated in parallel:
  - Any currently asserted pulse on that axis is deasserted.
  - If the axis GAP counter is nonzero, decrement it; no new pulse.
  - Otherwise, if backlog > 0: assert the p pulse and decrement the backlog by 1. If backlog < 0: assert the m pulse and increment the backlog by 1. A new pulse reloads the GAP counter with GAP.
- Consequence: a pulse rises at the end of one window, is stable through the entire next low window, and falls at the end of that window.
  - GAP=0 with a constant backlog gives alternating windows: asserted, deasserted, asserted...
  - With GAP=0, a pulse is therefore emitted every second window.
- p and m on the same axis are never asserted simultaneously, and the polarity never flips without an intervening deasserted window.
- LOAD:
  - Effective on the rising clock edge where it is sampled: backlog <= sat(backlog + DV), saturating to [-2^(CW-1), 2^(CW-1)-1]. Saturation sets OVF.
  - Same cycle as a window-end step on the same axis: backlog <= sat(backlog + DV - step), where step is +1/-1/0 as decided from the pre-load backlog.
  - A sign reversal by LOAD takes effect at the next window end; an already-asserted pulse completes normally.
- PIPSAM_ held high or held low: no pulse activity, and backlogs change only by LOAD.
- IDLE is combinational from registered state.

Test Plan:
- Reset check: rst=1 mid-window with PIPSAM_=0 -> all p/m outputs 0, _ outputs 1, IDLE=1, OVF=0. Release with PIPSAM_ low, then high -> no pulse.
- Basic drain, GAP=0: load X +3, then 8 PIPSAM_ windows -> PIPAXp high during windows 2, 4, 6 only; no other axis pulses. Backlog reaches 0 after the third pulse; IDLE=1 after the pulse falls.
- Negative, three axes in parallel: load Y -2 and Z +1 -> PIPAYm and PIPAZp both assert at the first window end. PIPAYm asserts again two windows later. PIPAYm_ is the complement throughout.
- Reversal: load X +1, and after the pulse rises load X -2 -> the p pulse completes. The next window is deasserted, then the m pulse follows, with net backlog -1 after the first m pulse and PIPAXp/PIPAXm never both high.
- Saturation and simultaneity: CW=8, load X +120 and then +20 -> backlog 127, OVF=1. Coincide LOAD +1 with a window-end decrement -> backlog unchanged at 127.
- GAP=2, load Z +2 -> PIPAZp asserted in windows 2 and 6. AXIS=3 loads are ignored.
